main_fsm: RTL
=============

# main_fsm

Multicycle control state machine for the RISC-V core: the producer of `aluOp` consumed by `aluDeco`, plus all datapath enables and mux selects. It is a Moore FSM, one state per instruction phase, decoding the 7-bit opcode of the instruction register. It targets the multicycle datapath with shared instruction/data memory and a single ALU used for PC increment, branch target, address and execute.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; forces FETCH
- `op`  in  7  opcode from instruction register
- `zero`  in  1  ALU zero flag
- `pcWrite`  out  1  PC load enable = `pcUpdate | (branch & zero)`
- `adrSrc`  out  1  memory address: 0=PC, 1=result
- `memWrite`  out  1  data memory write enable
- `irWrite`  out  1  instruction register / oldPC load
- `regWrite`  out  1  register file write enable
- `resultSrc`  out  2  00=aluOut, 01=memData, 10=ALU result
- `aluSrcA`  out  2  00=PC, 01=oldPC, 10=rs1 data
- `aluSrcB`  out  2  00=rs2 data, 01=immExt, 10=constant 4
- `aluOp`  out  2  to `aluDeco`: 00=add, 01=sub, 10=funct-decoded
- `illegal`  out  1  high while in DECODE with an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL. State register is the only storage.
- Outputs are a pure function of state (and `zero` for `pcWrite`). Any output not listed below is 0.
  - FETCH: `irWrite`=1, `pcUpdate`=1, `aluSrcA`=00, `aluSrcB`=10, `aluOp`=00, `resultSrc`=10.
  - DECODE: `aluSrcA`=01, `aluSrcB`=01, `aluOp`=00 (branch target precompute).
  - MEMADR: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=00.
  - MEMREAD: `adrSrc`=1, `resultSrc`=00.
  - MEMWB: `resultSrc`=01, `regWrite`=1.
  - MEMWRITE: `adrSrc`=1, `resultSrc`=00, `memWrite`=1.
  - EXECUTER: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=10.
  - EXECUTEI: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=10.
  - ALUWB: `resultSrc`=00, `regWrite`=1.
  - BEQ: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=01, `resultSrc`=00, `branch`=1.
  - JAL: `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00, `resultSrc`=00, `pcUpdate`=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE by `op`:
    - 0000011/0100011→MEMADR
    - 0110011→EXECUTER
    - 0010011→EXECUTEI
    - 1100011→BEQ
    - 1101111→JAL
    - other→FETCH with `illegal`=1.
  - MEMADR→MEMREAD if `op`=0000011, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI, JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ→FETCH.
- `op` is sampled only in DECODE and MEMADR. It is stable there because `irWrite` is low outside FETCH.
- Unreachable state encodings go to FETCH on the next edge.

## Timing
- Reset: at the rising edge with `reset`=1, state←FETCH. While `reset`=1, `pcWrite`, `memWrite`, `irWrite`, `regWrite` and `illegal` are forced 0 combinationally. Selects take FETCH values after the first reset edge.
- Reset asserted mid-instruction: the write enables are suppressed the same cycle, and FETCH is entered on the next edge.
- Cycles per instruction, FETCH to next FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - beq 3
  - jal 4
  - illegal 2
- `pcWrite` in BEQ follows `zero` combinationally in the same cycle.

## Configuration
- `MAIN_FSM_JAL_EN` defined: JAL state present; opcode 1101111 follows DECODE→JAL→ALUWB→FETCH.
- `MAIN_FSM_JAL_EN` undefined: no JAL state. Opcode 1101111 is treated as illegal: DECODE asserts `illegal`=1 and returns to FETCH.

## Test plan
- Reset held 2 cycles during EXECUTER, then released → `regWrite`/`memWrite`/`pcWrite`=0 while reset is high; first state FETCH with `irWrite`=1, `pcWrite`=1, `aluSrcB`=10.
- `op`=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `adrSrc`=1 in MEMREAD; `resultSrc`=01 and `regWrite`=1 in MEMWB; 5 cycles.
- `op`=0100011 → FETCH, DECODE, MEMADR, MEMWRITE. `memWrite`=1 only in the 4th cycle; `regWrite` never asserted.
- `op`=0110011, then `op`=0010011 → EXECUTER with `aluOp`=10, `aluSrcB`=00, then EXECUTEI with `aluSrcB`=01. Each followed by ALUWB with `regWrite`=1.
- `op`=1100011 run twice, once with `zero`=1 and once with `zero`=0 → BEQ `aluOp`=01; `pcWrite`=1 only when `zero`=1; 3 cycles each.
- `op`=1101111 → with macro: DECODE, JAL (`pcWrite`=1), ALUWB. Without macro: `illegal`=1 in DECODE, then FETCH. `op`=1111111 → `illegal`=1, then FETCH.

Source files
------------

// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle main FSM (master) and the datapath (slave).
// Carries the opcode/zero flag into the FSM and all enables and selects out of it.
interface main_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       illegal;

  modport master (
    input  op, zero,
    output pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluOp, illegal
  );

  modport slave (
    output op, zero,
    input  pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluOp, illegal
  );
endinterface

// File: rtl/main_fsm.sv
// Moore control FSM for the multicycle RISC-V core (one state per instruction phase).
// Define MAIN_FSM_JAL_EN to include the JAL state; otherwise opcode 1101111 decodes as illegal.
module main_fsm (
  input  logic          clk,
  input  logic          reset,
  main_fsm_if.master    bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef MAIN_FSM_JAL_EN
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
`ifdef MAIN_FSM_JAL_EN
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`else
    S_BEQ      = 4'd9
`endif
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       illegal_s;

  // State register; the only storage in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    next_state_s = S_FETCH;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_update_s  = 1'b1;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b10;
        alu_op_s     = 2'b00;
        result_src_s = 2'b10;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        // oldPC + imm is computed here so BEQ can compare while the target sits in aluOut.
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b00;
        case (bus.op)
          OP_LOAD:  next_state_s = S_MEMADR;
          OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE: next_state_s = S_EXECUTER;
          OP_IALU:  next_state_s = S_EXECUTEI;
          OP_BEQ:   next_state_s = S_BEQ;
`ifdef MAIN_FSM_JAL_EN
          OP_JAL:   next_state_s = S_JAL;
`endif
          default: begin
            illegal_s    = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b00;
        if (bus.op == OP_LOAD) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src_s    = 1'b1;
        result_src_s = 2'b00;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s    = 1'b1;
        result_src_s = 2'b00;
        mem_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b10;
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b01;
        alu_op_s     = 2'b10;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_s = 2'b00;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b01;
        result_src_s = 2'b00;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
`ifdef MAIN_FSM_JAL_EN
      S_JAL: begin
        // PC <- branch target in aluOut while oldPC + 4 becomes the link value.
        alu_src_a_s  = 2'b01;
        alu_src_b_s  = 2'b10;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        pc_update_s  = 1'b1;
        next_state_s = S_ALUWB;
      end
`endif
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Write enables and illegal are gated by reset so a mid-instruction reset commits nothing.
  assign bus.pcWrite   = ~reset & (pc_update_s | (branch_s & bus.zero));
  assign bus.memWrite  = ~reset & mem_write_s;
  assign bus.irWrite   = ~reset & ir_write_s;
  assign bus.regWrite  = ~reset & reg_write_s;
  assign bus.illegal   = ~reset & illegal_s;
  assign bus.adrSrc    = adr_src_s;
  assign bus.resultSrc = result_src_s;
  assign bus.aluSrcA   = alu_src_a_s;
  assign bus.aluSrcB   = alu_src_b_s;
  assign bus.aluOp     = alu_op_s;

endmodule
